pipe_ctrl_unit: RTL
===================

# pipe_ctrl_unit

Pipelined successor to the single-cycle opcode decoder. It decodes the ID-stage opcode into a control bundle and carries that bundle through ID/EX, EX/MEM and MEM/WB registers. It also detects load-use hazards, inserts bubbles, resolves taken branches and jumps into flush/PC-select signals, and honours an external pipeline freeze. It sits beside the datapath stage registers and drives every stage's control inputs.

## Interface
- OP_W, 6, opcode width
- RA_W, 5, register-address width
- ALUOP_W, 2, ALU-op field width
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- op_id  in  OP_W  opcode of instruction in ID
- rs_id, rt_id  in  RA_W  source register fields in ID
- alu_zero_mem  in  1  ALU zero flag registered into MEM
- stall_in  in  1  external freeze (e.g. memory wait)
- ex_reg_dst, ex_alu_src  out  1  EX-stage controls
- ex_alu_op  out  ALUOP_W  EX-stage ALU op
- mem_branch, mem_read, mem_write  out  1  MEM-stage controls
- wb_reg_write, wb_mem_to_reg  out  1  WB-stage controls
- pc_write, ifid_write  out  1  PC and IF/ID register enables
- ifid_flush  out  1  IF/ID is loaded with a NOP next edge
- pc_src_branch, pc_src_jump  out  1  PC mux selects
- illegal_op  out  1  sticky: undecodable opcode seen in ID

## Operation
- Decode is combinational, on op_id. Bundle = {RegWrite, MemtoReg | Branch, MemRead, MemWrite | RegDst, ALUOp, ALUSrc}.
  - 000000 R: 10|000|1,10,0
  - 100011 lw: 11|010|0,00,1
  - 101011 sw: 00|001|0,00,1
  - 000100 beq: 00|100|0,01,0
  - 001000 addi: 10|000|0,00,1
  - 000010 j: all zero, sets the jump flag
  - Any other opcode: all-zero bundle, and illegal_op sets (cleared only by rst). No latching of previous values.
- ID/EX captures the bundle plus rt_id. EX/MEM captures the EX bundle's M/WB parts. MEM/WB captures the WB parts.
- Load-use hazard: ex_mem_read_idex && (rt_ex == rs_id || rt_ex == rt_id), with rt_ex != 0.
  - Outputs: pc_write=0, ifid_write=0.
  - ID/EX loads a zero bundle. EX/MEM and MEM/WB advance.
- Branch: pc_src_branch = mem_branch & alu_zero_mem.
  - When asserted: ifid_flush=1, and ID/EX and EX/MEM load zero bundles next edge. MEM/WB advances.
- Jump: pc_src_jump = (op_id == 000010) with no hazard. When asserted: ifid_flush=1, and ID/EX loads a zero bundle.
- Priority, per edge: rst > stall_in > pc_src_branch > hazard > pc_src_jump > normal.
  - stall_in: all three stage registers hold. pc_write=0, ifid_write=0, ifid_flush=0. pc_src_* still reflect held state.
  - Branch over hazard: pc_write=1, ifid_write=1 (the hazard instruction is on the wrong path).
  - A jump in the shadow of a taken branch is discarded.

## Timing
- Reset: all stage registers and illegal_op clear, so every ex_/mem_/wb_ output is 0.
  - While rst=1: pc_write=0, ifid_write=0, ifid_flush=0, pc_src_*=0.
  - First cycle after rst: pc_write=1, ifid_write=1.
- Latency: op_id at edge N appears on ex_* after edge N, mem_* after N+1, wb_* after N+2.
- Hazard costs exactly one bubble. pc_write deasserts only in the hazard cycle.
- Branch taken in MEM costs three slots: IF/ID, ID/EX and EX/MEM are all squashed on the same edge.
- Jump costs one slot.
- rst mid-stall or mid-flush: clears everything on that edge, with no residual bubble state.

## Configuration
- PIPE_CTRL_HAZARD_EN defined: load-use detector is compiled in, as above.
- PIPE_CTRL_HAZARD_EN undefined:
  - Hazard term is a constant 0, and rt_id is not stored.
  - pc_write/ifid_write depend only on rst and stall_in.
  - Software must schedule load delay slots.

## Test plan
- Reset then R-type (op 000000) at edge 1 -> ex_reg_dst=1, ex_alu_op=10 after edge 1; wb_reg_write=1, wb_mem_to_reg=0 after edge 3.
- lw writing rt=5, then R-type with rs_id=5 -> the next cycle has pc_write=0, ifid_write=0 and zero bubble in ID/EX; the R-type proceeds one cycle later. With the macro off, there is no stall.
- beq with alu_zero_mem=1 in MEM -> pc_src_branch=1, ifid_flush=1; next cycle ex_* and mem_* are 0. With alu_zero_mem=0 -> no flush.
- op 000010 in ID -> pc_src_jump=1, ifid_flush=1; next cycle ex_* are 0.
- stall_in=1 for 3 cycles with lw in EX -> all stage outputs held for 3 cycles, pc_write=0; resumes unchanged.
- op 111111 -> zero bundle, illegal_op=1 held until rst; taken branch coincident with hazard -> branch wins, pc_write=1.

Source files
------------

// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit: ID-stage opcode decode carried through ID/EX, EX/MEM and MEM/WB control registers,
// with branch/jump flush and external freeze. Define PIPE_CTRL_HAZARD_EN to compile in the load-use stall.
module pipe_ctrl_unit #(
  parameter int OP_W    = 6,
  parameter int RA_W    = 5,
  parameter int ALUOP_W = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [OP_W-1:0]    op_id,
  input  logic [RA_W-1:0]    rs_id,
  input  logic [RA_W-1:0]    rt_id,
  input  logic               alu_zero_mem,
  input  logic               stall_in,
  output logic               ex_reg_dst,
  output logic               ex_alu_src,
  output logic [ALUOP_W-1:0] ex_alu_op,
  output logic               mem_branch,
  output logic               mem_read,
  output logic               mem_write,
  output logic               wb_reg_write,
  output logic               wb_mem_to_reg,
  output logic               pc_write,
  output logic               ifid_write,
  output logic               ifid_flush,
  output logic               pc_src_branch,
  output logic               pc_src_jump,
  output logic               illegal_op
);

  localparam logic [OP_W-1:0] OP_R    = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_LW   = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW   = OP_W'(6'b101011);
  localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_ADDI = OP_W'(6'b001000);
  localparam logic [OP_W-1:0] OP_J    = OP_W'(6'b000010);

  typedef struct packed {
    logic               reg_write;
    logic               mem_to_reg;
    logic               branch;
    logic               mem_read;
    logic               mem_write;
    logic               reg_dst;
    logic [ALUOP_W-1:0] alu_op;
    logic               alu_src;
  } idex_t;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
    logic branch;
    logic mem_read;
    logic mem_write;
  } exmem_t;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
  } memwb_t;

  idex_t  dec, idex_d, idex_q;
  exmem_t exmem_d, exmem_q;
  memwb_t memwb_d, memwb_q;
  logic   dec_jump, dec_illegal;
  logic   illegal_d, illegal_q;
  logic   hazard, branch_taken, jump_taken;

  always_comb begin
    dec         = '0;
    dec_jump    = 1'b0;
    dec_illegal = 1'b0;
    case (op_id)
      OP_R: begin
        dec.reg_write = 1'b1;
        dec.reg_dst   = 1'b1;
        dec.alu_op    = ALUOP_W'(2'b10);
      end
      OP_LW: begin
        dec.reg_write  = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.mem_read   = 1'b1;
        dec.alu_src    = 1'b1;
      end
      OP_SW: begin
        dec.mem_write = 1'b1;
        dec.alu_src   = 1'b1;
      end
      OP_BEQ: begin
        dec.branch = 1'b1;
        dec.alu_op = ALUOP_W'(2'b01);
      end
      OP_ADDI: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
      end
      OP_J:    dec_jump    = 1'b1;
      default: dec_illegal = 1'b1;
    endcase
  end

`ifdef PIPE_CTRL_HAZARD_EN
  logic [RA_W-1:0] rt_ex_d, rt_ex_q;

  // Register 0 is hardwired, so a load targeting it never creates a dependency.
  assign hazard = idex_q.mem_read && (rt_ex_q != '0) &&
                  ((rt_ex_q == rs_id) || (rt_ex_q == rt_id));

  always_comb begin
    rt_ex_d = rt_ex_q;
    if (!stall_in) rt_ex_d = rt_id;
  end

  always_ff @(posedge clk) begin
    if (rst) rt_ex_q <= '0;
    else     rt_ex_q <= rt_ex_d;
  end
`else
  logic unused_id_fields;
  assign hazard           = 1'b0;
  assign unused_id_fields = ^{rs_id, rt_id};
`endif

  assign branch_taken = exmem_q.branch & alu_zero_mem;
  // A jump behind a taken branch or a stalled load is on a path that will be refetched.
  assign jump_taken   = dec_jump & ~hazard & ~branch_taken;

  assign pc_src_branch = ~rst & branch_taken;
  assign pc_src_jump   = ~rst & jump_taken;
  assign pc_write      = ~rst & ~stall_in & (branch_taken | ~hazard);
  assign ifid_write    = ~rst & ~stall_in & (branch_taken | ~hazard);
  assign ifid_flush    = ~rst & ~stall_in & (branch_taken | jump_taken);

  always_comb begin
    idex_d    = idex_q;
    exmem_d   = exmem_q;
    memwb_d   = memwb_q;
    illegal_d = illegal_q | dec_illegal;
    if (!stall_in) begin
      memwb_d.reg_write  = exmem_q.reg_write;
      memwb_d.mem_to_reg = exmem_q.mem_to_reg;
      exmem_d.reg_write  = idex_q.reg_write;
      exmem_d.mem_to_reg = idex_q.mem_to_reg;
      exmem_d.branch     = idex_q.branch;
      exmem_d.mem_read   = idex_q.mem_read;
      exmem_d.mem_write  = idex_q.mem_write;
      idex_d             = dec;
      if (branch_taken) begin
        idex_d  = '0;
        exmem_d = '0;
      end else if (hazard) begin
        idex_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idex_q    <= '0;
      exmem_q   <= '0;
      memwb_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      idex_q    <= idex_d;
      exmem_q   <= exmem_d;
      memwb_q   <= memwb_d;
      illegal_q <= illegal_d;
    end
  end

  assign ex_reg_dst    = idex_q.reg_dst;
  assign ex_alu_src    = idex_q.alu_src;
  assign ex_alu_op     = idex_q.alu_op;
  assign mem_branch    = exmem_q.branch;
  assign mem_read      = exmem_q.mem_read;
  assign mem_write     = exmem_q.mem_write;
  assign wb_reg_write  = memwb_q.reg_write;
  assign wb_mem_to_reg = memwb_q.mem_to_reg;
  assign illegal_op    = illegal_q;

endmodule
